// File: rtl/alu_op_issue_stage.sv
// alu_op_issue_stage: decodes one RV32I instruction into an ALU op code, operand-source
// selects, immediate and control flags, and holds the result in a single-entry
// valid/ready pipeline register feeding execute. Also counts accepted illegal
// instructions (saturating) for debug.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (instr, pc_in)
//   flush                 drop the held bundle and block loading this cycle
//   out_valid / out_ready downstream handshake
//   op_select, imm, rs1, rs2, rd, pc_out   registered decoded bundle
//   alu_src_imm, src_a_pc, src_a_zero      ALU operand selects
//   reg_write, mem_read, mem_write, is_branch, is_jump   control flags
//   illegal               held instruction could not be decoded
//   ill_count             saturating count of accepted illegal instructions
module alu_op_issue_stage #(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           op_select,
    output logic [31:0]          imm,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          pc_out,
    output logic                 alu_src_imm,
    output logic                 src_a_pc,
    output logic                 src_a_zero,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpXor  = 5'd2;
    localparam logic [4:0] OpOr   = 5'd3;
    localparam logic [4:0] OpAnd  = 5'd4;
    localparam logic [4:0] OpSll  = 5'd5;
    localparam logic [4:0] OpSrl  = 5'd6;
    localparam logic [4:0] OpSra  = 5'd7;
    localparam logic [4:0] OpSlt  = 5'd8;
    localparam logic [4:0] OpSltu = 5'd9;
    localparam logic [4:0] OpBeq  = 5'd10;
    localparam logic [4:0] OpBne  = 5'd11;
    localparam logic [4:0] OpBlt  = 5'd12;
    localparam logic [4:0] OpBge  = 5'd13;
    localparam logic [4:0] OpBltu = 5'd14;
    localparam logic [4:0] OpBgeu = 5'd15;
    localparam logic [4:0] OpJump = 5'd16;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, sh_imm;
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};
    assign sh_imm = {27'b0, instr[24:20]};

    logic [4:0]  dec_op;
    logic [31:0] dec_imm;
    logic        dec_src_imm, dec_a_pc, dec_a_zero, dec_rw, dec_mr, dec_mw, dec_br, dec_jmp;
    logic        dec_illegal;

    always_comb begin
        dec_op      = OpAdd;
        dec_imm     = '0;
        dec_src_imm = 1'b0;
        dec_a_pc    = 1'b0;
        dec_a_zero  = 1'b0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_br      = 1'b0;
        dec_jmp     = 1'b0;
        dec_illegal = 1'b0;

        case (opcode)
            OpcOp: begin
                dec_rw = 1'b1;
                if (funct7 == F7Zero) begin
                    case (funct3)
                        3'b000:  dec_op = OpAdd;
                        3'b001:  dec_op = OpSll;
                        3'b010:  dec_op = OpSlt;
                        3'b011:  dec_op = OpSltu;
                        3'b100:  dec_op = OpXor;
                        3'b101:  dec_op = OpSrl;
                        3'b110:  dec_op = OpOr;
                        default: dec_op = OpAnd;
                    endcase
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    dec_op = OpSub;
                end else if (funct7 == F7Alt && funct3 == 3'b101) begin
                    dec_op = OpSra;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = i_imm;
                case (funct3)
                    3'b000:  dec_op = OpAdd;
                    3'b010:  dec_op = OpSlt;
                    3'b011:  dec_op = OpSltu;
                    3'b100:  dec_op = OpXor;
                    3'b110:  dec_op = OpOr;
                    3'b111:  dec_op = OpAnd;
                    3'b001: begin
                        dec_op      = OpSll;
                        dec_imm     = sh_imm;
                        dec_illegal = (funct7 != F7Zero);
                    end
                    default: begin
                        // 101: funct7 picks SRLI vs SRAI; anything else in [31:25] is bad
                        dec_imm = sh_imm;
                        if (funct7 == F7Zero) begin
                            dec_op = OpSrl;
                        end else if (funct7 == F7Alt) begin
                            dec_op = OpSra;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                endcase
            end
            OpcLoad: begin
                dec_src_imm = 1'b1;
                dec_mr      = 1'b1;
                dec_rw      = 1'b1;
                dec_imm     = i_imm;
            end
            OpcStore: begin
                dec_src_imm = 1'b1;
                dec_mw      = 1'b1;
                dec_imm     = s_imm;
            end
            OpcBranch: begin
                dec_br  = 1'b1;
                dec_imm = b_imm;
                case (funct3)
                    3'b000:  dec_op = OpBeq;
                    3'b001:  dec_op = OpBne;
                    3'b100:  dec_op = OpBlt;
                    3'b101:  dec_op = OpBge;
                    3'b110:  dec_op = OpBltu;
                    3'b111:  dec_op = OpBgeu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpcJal: begin
                dec_op  = OpJump;
                dec_imm = j_imm;
                dec_jmp = 1'b1;
                dec_rw  = 1'b1;
            end
            OpcJalr: begin
                dec_op      = OpJump;
                dec_imm     = i_imm;
                dec_jmp     = 1'b1;
                dec_rw      = 1'b1;
                dec_illegal = (funct3 != 3'b000);
            end
            OpcLui: begin
                dec_a_zero  = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = u_imm;
                dec_rw      = 1'b1;
            end
            OpcAuipc: begin
                dec_a_pc    = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = u_imm;
                dec_rw      = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal bundles carry no side effects into execute, only the trap flag.
        if (dec_illegal) begin
            dec_op      = OpAdd;
            dec_imm     = '0;
            dec_src_imm = 1'b0;
            dec_a_pc    = 1'b0;
            dec_a_zero  = 1'b0;
            dec_rw      = 1'b0;
            dec_mr      = 1'b0;
            dec_mw      = 1'b0;
            dec_br      = 1'b0;
            dec_jmp     = 1'b0;
        end
    end

    logic load;
    assign in_ready = !flush && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            op_select   <= '0;
            imm         <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            pc_out      <= '0;
            alu_src_imm <= 1'b0;
            src_a_pc    <= 1'b0;
            src_a_zero  <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            is_branch   <= 1'b0;
            is_jump     <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            op_select   <= dec_op;
            imm         <= dec_imm;
            rs1         <= instr[19:15];
            rs2         <= instr[24:20];
            rd          <= instr[11:7];
            pc_out      <= pc_in;
            alu_src_imm <= dec_src_imm;
            src_a_pc    <= dec_a_pc;
            src_a_zero  <= dec_a_zero;
            reg_write   <= dec_rw;
            mem_read    <= dec_mr;
            mem_write   <= dec_mw;
            is_branch   <= dec_br;
            is_jump     <= dec_jmp;
            illegal     <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // load is already gated by flush through in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_count <= '0;
        end else if (load && dec_illegal && (ill_count != {ILL_CNT_W{1'b1}})) begin
            ill_count <= ill_count + 1'b1;
        end
    end

endmodule

// File: doc/alu_op_issue_stage.md
Name: alu_op_issue_stage

Overview:
- Decode-side producer of the ALU's 5-bit `op_select` code.
- Takes a fetched RV32I instruction, decodes it into ALU op, operand-source selects, immediate and control flags, and holds the result in a single-entry valid/ready pipeline register feeding the execute stage.
- Sits between the fetch buffer and the ALU/regfile-read logic.
- Also counts illegal instructions for debug.

Parameters:
- `ILL_CNT_W`, default 8: width of the saturating illegal-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: the instruction/pc inputs are valid.
- `in_ready` out 1: the stage accepts an instruction this cycle.
- `instr` in 32: raw instruction word.
- `pc_in` in 32: PC of `instr`.
- `flush` in 1: discard the held instruction and block loading this cycle.
- `out_valid` out 1: the decoded bundle is valid.
- `out_ready` in 1: execute consumes the bundle.
- `op_select` out 5: ALU op code, using the ALU encoding listed under Behaviour.
- `imm` out 32: sign/zero-extended immediate.
- `rs1` out 5, `rs2` out 5, `rd` out 5: register indices.
- `pc_out` out 32: registered PC.
- `alu_src_imm` out 1: ALU in2 = `imm` (else rs2 data).
- `src_a_pc` out 1: ALU in1 = `pc_out`.
- `src_a_zero` out 1: ALU in1 = 0.
- `reg_write`, `mem_read`, `mem_write`, `is_branch`, `is_jump` out 1 each: control flags.
- `illegal` out 1: the held instruction is undecodable.
- `ill_count` out `ILL_CNT_W`: saturating count of illegal instructions accepted.

Behaviour:
- ALU code map: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 JUMP.
- Opcode `0110011` (R-type):
  - ALU op from funct3/funct7.
  - funct7 `0100000` is valid only with funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 ≠ 0 is illegal.
  - `reg_write`=1, `imm`=0.
- Opcode `0010011` (I-ALU):
  - `alu_src_imm`=1, `reg_write`=1.
  - `imm` = sign-extended `instr[31:20]`.
  - For SLLI/SRLI/SRAI, `imm` = zero-extended `instr[24:20]`.
  - `instr[31:25]` must be 0, or `0100000` for SRAI only; otherwise illegal.
- Load `0000011` and store `0100011`:
  - op 0, `alu_src_imm`=1.
  - Load: `mem_read`=1, `reg_write`=1, I-immediate.
  - Store: `mem_write`=1, S-immediate.
- Branch `1100011`:
  - op 10–15 for funct3 000, 001, 100, 101, 110, 111; funct3 010/011 are illegal.
  - B-immediate, `is_branch`=1.
- JAL `1101111`: op 16, J-immediate, `is_jump`=1, `reg_write`=1.
- JALR `1100111` (funct3 must be 000): op 16, I-immediate, `is_jump`=1, `reg_write`=1.
- LUI `0110111`: op 0, `src_a_zero`=1, `alu_src_imm`=1, `imm` = `{instr[31:12], 12'b0}`, `reg_write`=1.
- AUIPC `0010111`: same as LUI but `src_a_pc`=1 instead of `src_a_zero`.
- Any other opcode is illegal.
- Illegal bundle: `illegal`=1; all control flags, `op_select` and `imm` = 0. `out_valid` still asserts so execute can trap.
- Handshake:
  - `in_ready` = `!out_valid || out_ready`, combinational, and forced 0 while `flush`=1.
  - Load occurs when `in_valid && in_ready`. Decode is combinational on `instr`; all outputs are registered, so latency is 1 cycle from acceptance to `out_valid`.
  - Without a load: `out_valid` clears when `out_ready`=1; otherwise the bundle holds stable.
  - Simultaneous consume and load: the new bundle replaces the old with no bubble.
- Flush has highest priority: next cycle `out_valid`=0, nothing loaded, and `ill_count` is not incremented for the blocked input.
- `ill_count` increments by 1 on each accepted illegal instruction and saturates at all-ones.
- Reset (asynchronous, any time including mid-handshake):
  - `out_valid`=0, `ill_count`=0.
  - All registered bundle fields = 0, including `op_select`=0 and `illegal`=0.
  - The first load is possible on the first edge after `rst_n` rises.

Test Plan:
- Reset then `instr`=0x002081B3 (ADD x3,x1,x2), `out_ready`=1 -> one cycle later `out_valid`=1, `op_select`=0, `rd`=3, `rs1`=1, `rs2`=2, `reg_write`=1, `alu_src_imm`=0.
- `instr`=0x407302B3 (SUB) -> `op_select`=1, `rd`=5. Then 0x40315093 (SRAI x1,x2,3) -> `op_select`=7, `imm`=3, `alu_src_imm`=1.
- `instr`=0xFE20CEE3 (BLT x1,x2,-4) -> `op_select`=12, `imm`=0xFFFFFFFC, `is_branch`=1, `reg_write`=0.
- Backpressure: load ADD, hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, bundle stable. Raise `out_ready` -> next instruction loads the same edge, no bubble.
- `flush`=1 while `out_valid`=1 and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready` was 0 during flush.
- `instr`=0x00000000 accepted 300 times with `ILL_CNT_W`=8 -> each bundle has `illegal`=1, `op_select`=0, `reg_write`=0; `ill_count` ends at 255. Assert `rst_n`=0 mid-stream -> `ill_count`=0 and `out_valid`=0 immediately.
